m_display_scheduler: RTL and testbench

//  Sequences the six-digit 7-segment result display across a bank of watched

---
 rtl/m_display_scheduler_pkg.sv | 18 +
 rtl/m_rr_arbiter.sv | 41 ++++
 rtl/m_display_scheduler.sv | 133 +++++++++++++
 tb/tb_m_display_scheduler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/m_display_scheduler_pkg.sv
// rtl/m_display_scheduler_pkg.sv - shared constants and state encodings for the display scheduler
// Purpose: default watched-register window, MIPS register numbers, FSM states.
// Ports: none (package).
package m_display_scheduler_pkg;

  localparam int BASE_REG_DEF  = 16;
  localparam int NUM_WATCH_DEF = 8;

  localparam logic [4:0] REG_T0 = 5'd8;
  localparam logic [4:0] REG_S0 = 5'd16;
  localparam logic [4:0] REG_S7 = 5'd23;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } sched_state_t;

endpackage

// File: rtl/m_rr_arbiter.sv
// rtl/m_rr_arbiter.sv - combinational round-robin arbiter
// Purpose: pick the first set request after the pointer, wrapping N-1 -> 0.
// Ports:
//   req        in   N       request vector
//   ptr        in   IDX_W   last granted index (search starts at ptr+1)
//   grant_oh   out  N       one-hot grant
//   grant_idx  out  IDX_W   binary index of the grant
//   any_grant  out  1       at least one request is set
module m_rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  int               j;
  logic [IDX_W-1:0] jj;

  // Offset 1..N visits every index exactly once, ptr itself last.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    j         = 0;
    jj        = '0;
    for (int i = 1; i <= N; i++) begin
      j  = (int'(ptr) + i) % N;
      jj = IDX_W'(j);
      if (!any_grant && req[jj]) begin
        any_grant    = 1'b1;
        grant_idx    = jj;
        grant_oh[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/m_display_scheduler.sv
// rtl/m_display_scheduler.sv - round-robin 7-segment display sequencer over watched registers
// Purpose: snoops WB writes into a shadow bank, marks them dirty, and shows
//   each updated register for DWELL cycles in round-robin order.
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   reg_write/write_reg/write_data   WB register-file write snoop
//   hold                  freeze dwell countdown
//   step                  end current dwell now
//   disp_value/disp_sel   displayed value and watched index
//   disp_valid            something has been shown since reset
//   disp_load             strobe when disp_value/disp_sel change
//   dirty_mask            written-but-not-yet-shown registers
module m_display_scheduler
  import m_display_scheduler_pkg::*;
#(
  parameter int BASE_REG  = BASE_REG_DEF,
  parameter int NUM_WATCH = NUM_WATCH_DEF,
  parameter int DWELL     = 50_000_000,
  parameter int DISP_W    = 24,
  parameter int IDX_W     = $clog2(NUM_WATCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reg_write,
  input  logic [4:0]           write_reg,
  input  logic [31:0]          write_data,
  input  logic                 hold,
  input  logic                 step,
  output logic [DISP_W-1:0]    disp_value,
  output logic [IDX_W-1:0]     disp_sel,
  output logic                 disp_valid,
  output logic                 disp_load,
  output logic [NUM_WATCH-1:0] dirty_mask
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  sched_state_t         state_q, state_d;
  logic [DISP_W-1:0]    shadow [NUM_WATCH];
  logic [NUM_WATCH-1:0] dirty_q, dirty_d;
  logic [DW_W-1:0]      dwell_q, dwell_d;
  logic [IDX_W-1:0]     rr_ptr;

  logic [5:0]           rel;
  logic                 hit;
  logic [IDX_W-1:0]     hit_idx;
  logic [NUM_WATCH-1:0] grant_oh;
  logic [IDX_W-1:0]     grant_idx;
  logic                 any_grant;
  logic                 do_grant, refresh, expire;

  if (DISP_W < 32) begin : g_unused
    logic unused_wd;
    assign unused_wd = ^write_data[31:DISP_W];
  end

  assign rel     = {1'b0, write_reg} - 6'(BASE_REG);
  assign hit     = reg_write && ({1'b0, write_reg} >= 6'(BASE_REG)) && (rel < 6'(NUM_WATCH));
  assign hit_idx = rel[IDX_W-1:0];

  m_rr_arbiter #(.N(NUM_WATCH), .IDX_W(IDX_W)) u_arb (
    .req       (dirty_q),
    .ptr       (rr_ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    refresh  = 1'b0;
    expire   = 1'b0;
    dwell_d  = dwell_q;
    case (state_q)
      ST_IDLE: begin
        if (any_grant) begin
          do_grant = 1'b1;
          state_d  = ST_SHOW;
        end
      end
      ST_SHOW: begin
        expire = step || (dwell_q == '0 && !hold);
        if (expire && any_grant)                  do_grant = 1'b1;
        else if (hit && hit_idx == disp_sel)      refresh  = 1'b1;
        else if (step)                            dwell_d  = '0;
        else if (!hold && dwell_q != '0)          dwell_d  = dwell_q - DW_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (do_grant || refresh) dwell_d = DW_W'(DWELL - 1);
    // A refresh of the shown register never marks it pending; a grant
    // clears its own bit last so a same-cycle write to it is consumed.
    dirty_d = dirty_q;
    if (hit && !refresh) dirty_d[hit_idx] = 1'b1;
    if (do_grant)        dirty_d = dirty_d & ~grant_oh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WATCH; i++) shadow[i] <= '0;
      dirty_q    <= '0;
      dwell_q    <= '0;
      rr_ptr     <= IDX_W'(NUM_WATCH - 1);
      disp_value <= '0;
      disp_sel   <= '0;
      disp_valid <= 1'b0;
      disp_load  <= 1'b0;
    end else begin
      if (hit) shadow[hit_idx] <= write_data[DISP_W-1:0];
      dirty_q   <= dirty_d;
      dwell_q   <= dwell_d;
      disp_load <= do_grant || refresh;
      if (do_grant) begin
        rr_ptr     <= grant_idx;
        disp_sel   <= grant_idx;
        disp_valid <= 1'b1;
        disp_value <= (hit && hit_idx == grant_idx) ? write_data[DISP_W-1:0]
                                                    : shadow[grant_idx];
      end else if (refresh) begin
        disp_value <= write_data[DISP_W-1:0];
      end
    end
  end

  assign dirty_mask = dirty_q;

endmodule

// File: tb/tb_m_display_scheduler.sv
// tb/tb_m_display_scheduler.sv - self-checking bench for m_display_scheduler
module tb_m_display_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        hold;
  logic        step;
  logic [23:0] disp_value;
  logic [2:0]  disp_sel;
  logic        disp_valid;
  logic        disp_load;
  logic [7:0]  dirty_mask;

  m_display_scheduler #(.DWELL(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .hold       (hold),
    .step       (step),
    .disp_value (disp_value),
    .disp_sel   (disp_sel),
    .disp_valid (disp_valid),
    .disp_load  (disp_load),
    .dirty_mask (dirty_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        hold;
    logic        step;
    logic        load;
    logic [2:0]  sel;
    logic [23:0] val;
    logic        valid;
    logic [7:0]  dirty;
  } vec_t;

  typedef struct {
    logic [2:0]  sel;
    logic [23:0] val;
  } show_t;

  vec_t  vecs[$];
  show_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input int rw, input int wr, input logic [31:0] wd, input int hd, input int st,
                     input int ld, input int sel, input logic [23:0] val, input int vl, input int dirty);
    vec_t v;
    v.rw = 1'(rw); v.wr = 5'(wr); v.wd = wd; v.hold = 1'(hd); v.step = 1'(st);
    v.load = 1'(ld); v.sel = 3'(sel); v.val = val; v.valid = 1'(vl); v.dirty = 8'(dirty);
    vecs.push_back(v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_show(input int sel, input logic [23:0] val);
    show_t s;
    s.sel = 3'(sel);
    s.val = val;
    exp_q.push_back(s);
  endtask

  task automatic drive(input int rw, input int wr, input logic [31:0] wd, input int hd, input int st);
    reg_write = 1'(rw); write_reg = 5'(wr); write_data = wd; hold = 1'(hd); step = 1'(st);
  endtask

  // Scoreboard: every display load must match the oldest expected show.
  always @(posedge clk) begin
    #1;
    if (disp_load) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected_load: got sel %0d val %h expected no load", disp_sel, disp_value);
      end else begin
        show_t e;
        e = exp_q.pop_front();
        chk("sb_sel", 32'(disp_sel), 32'(e.sel));
        chk("sb_val", 32'(disp_value), 32'(e.val));
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);

    //  rw wr  wd              h s | ld sel val      v dirty
    add(1, 17, 32'h00ABCDEF,  0,0,  0, 0, 24'h0,     0, 'h02);
    add(0, 0,  0,             0,0,  1, 1, 24'hABCDEF,1, 'h00);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0, 0,1,24'hABCDEF,1,'h00);
    add(1, 16, 1,             0,0,  0, 1, 24'hABCDEF,1, 'h01);
    add(1, 19, 3,             0,0,  1, 0, 24'h1,     1, 'h08);
    add(1, 23, 7,             0,0,  0, 0, 24'h1,     1, 'h88);
    for (int i = 0; i < 2; i++) add(0,0,0,0,0, 0,0,24'h1,1,'h88);
    add(0, 0,  0,             0,0,  1, 3, 24'h3,     1, 'h80);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0, 0,3,24'h3,1,'h80);
    add(0, 0,  0,             0,0,  1, 7, 24'h7,     1, 'h00);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0, 0,7,24'h7,1,'h00);
    add(1, 21, 32'h500,       0,0,  0, 7, 24'h7,     1, 'h20);
    add(0, 0,  0,             0,0,  1, 5, 24'h500,   1, 'h00);
    add(1, 16, 32'h11,        0,0,  0, 5, 24'h500,   1, 'h01);
    add(1, 16, 32'h22,        0,0,  0, 5, 24'h500,   1, 'h01);
    add(0, 0,  0,             0,0,  0, 5, 24'h500,   1, 'h01);
    add(0, 0,  0,             0,0,  1, 0, 24'h22,    1, 'h00);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0, 0,0,24'h22,1,'h00);
    add(1, 18, 32'h2,         0,0,  0, 0, 24'h22,    1, 'h04);
    add(0, 0,  0,             0,0,  1, 2, 24'h2,     1, 'h00);
    add(0, 0,  0,             0,0,  0, 2, 24'h2,     1, 'h00);
    add(1, 18, 32'h55,        0,0,  1, 2, 24'h55,    1, 'h00);
    add(0, 0,  0,             0,0,  0, 2, 24'h55,    1, 'h00);
    add(1, 22, 32'h6,         0,0,  0, 2, 24'h55,    1, 'h40);
    add(0, 0,  0,             0,0,  0, 2, 24'h55,    1, 'h40);
    add(0, 0,  0,             0,0,  1, 6, 24'h6,     1, 'h00);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0, 0,6,24'h6,1,'h00);
    add(1, 20, 32'h44,        1,0,  0, 6, 24'h6,     1, 'h10);
    for (int i = 0; i < 2; i++) add(0,0,0,1,0, 0,6,24'h6,1,'h10);
    add(0, 0,  0,             1,1,  1, 4, 24'h44,    1, 'h00);
    add(1, 8,  32'hDEAD,      1,0,  0, 4, 24'h44,    1, 'h00);
    add(1, 31, 32'hBEEF,      0,0,  0, 4, 24'h44,    1, 'h00);
    add(1, 15, 32'hBEEF,      0,0,  0, 4, 24'h44,    1, 'h00);
    add(1, 24, 32'hBEEF,      0,0,  0, 4, 24'h44,    1, 'h00);
    add(1, 23, 32'h77,        0,0,  0, 4, 24'h44,    1, 'h80);
    add(0, 0,  0,             0,0,  1, 7, 24'h77,    1, 'h00);
    add(1, 17, 32'h10,        0,0,  0, 7, 24'h77,    1, 'h02);
    add(1, 17, 32'h20,        0,0,  0, 7, 24'h77,    1, 'h02);
    add(0, 0,  0,             0,0,  0, 7, 24'h77,    1, 'h02);
    add(1, 17, 32'hFF000030,  0,0,  1, 1, 24'h30,    1, 'h00);
    add(0, 0,  0,             0,1,  0, 1, 24'h30,    1, 'h00);
    add(1, 19, 32'h33,        0,0,  0, 1, 24'h30,    1, 'h08);
    add(0, 0,  0,             0,0,  1, 3, 24'h33,    1, 'h00);

    tick();
    tick();
    rst = 1'b0;
    chk("rst_value", 32'(disp_value), 0);
    chk("rst_sel",   32'(disp_sel),   0);
    chk("rst_valid", 32'(disp_valid), 0);
    chk("rst_load",  32'(disp_load),  0);
    chk("rst_dirty", 32'(dirty_mask), 0);

    foreach (vecs[k]) begin
      drive(vecs[k].rw, vecs[k].wr, vecs[k].wd, vecs[k].hold, vecs[k].step);
      if (vecs[k].load) push_show(vecs[k].sel, vecs[k].val);
      tick();
      chk($sformatf("v%0d_load", k),  32'(disp_load),  32'(vecs[k].load));
      chk($sformatf("v%0d_sel", k),   32'(disp_sel),   32'(vecs[k].sel));
      chk($sformatf("v%0d_val", k),   32'(disp_value), 32'(vecs[k].val));
      chk($sformatf("v%0d_valid", k), 32'(disp_valid), 32'(vecs[k].valid));
      chk($sformatf("v%0d_dirty", k), 32'(dirty_mask), 32'(vecs[k].dirty));
    end

    // Asynchronous reset between edges while showing with a pending write.
    drive(1, 21, 32'h99, 0, 0);
    tick();
    chk("pre_rst_dirty", 32'(dirty_mask), 32'h20);
    drive(0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_value", 32'(disp_value), 0);
    chk("arst_sel",   32'(disp_sel),   0);
    chk("arst_valid", 32'(disp_valid), 0);
    chk("arst_load",  32'(disp_load),  0);
    chk("arst_dirty", 32'(dirty_mask), 0);
    tick();
    rst = 1'b0;

    // hold is ignored in IDLE; pointer restarts so index 7 is searched last.
    drive(1, 18, 32'h2222, 1, 0);
    push_show(2, 24'h2222);
    tick();
    chk("post_rst_dirty", 32'(dirty_mask), 32'h04);
    drive(0, 0, 0, 1, 0);
    tick();
    chk("post_rst_load", 32'(disp_load), 1);
    chk("post_rst_sel",  32'(disp_sel),  2);
    drive(1, 23, 32'h77, 0, 0);
    push_show(7, 24'h77);
    tick();
    drive(1, 17, 32'h11, 0, 0);
    push_show(1, 24'h11);
    tick();
    chk("rr_dirty", 32'(dirty_mask), 32'h82);
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rr_first_sel",  32'(disp_sel),  7);
    chk("rr_first_load", 32'(disp_load), 1);
    for (int i = 0; i < 4; i++) tick();
    chk("rr_second_sel",  32'(disp_sel),  1);
    chk("rr_second_load", 32'(disp_load), 1);
    for (int i = 0; i < 6; i++) tick();
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
